deadlock_idx0_monitor: RTL and testbench

- Simulation-support deadlock detector for dataflow kernel index 0 (single dataflow process, two AXI-Stream ports).
- Combines per-port AXIS stall flags, process idle flags and process done-but-not-continued flags.
- Asserts `block` once the kernel has been continuously stalled, while not idle, for a programmable number of cycles.
- The enclosing kernel monitor uses `block` to trigger deadlock-path reporting.

---
 rtl/deadlock_idx0_monitor.sv | 54 +++++
 tb/tb_deadlock_idx0_monitor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/deadlock_idx0_monitor.sv
// Deadlock detector for dataflow kernel index 0: raises `block` once the single
// process has been continuously stalled, with the kernel not idle, for THRESHOLD cycles.
module deadlock_idx0_monitor #(
  parameter int THRESHOLD = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] axis_block_sigs,
  input  logic [2:0] inst_idle_sigs,
  input  logic [0:0] inst_block_sigs,
  output logic       block
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH:0]   THRESH_EX = (CNT_WIDTH+1)'(THRESHOLD);

  logic                 proc0_stall;
  logic                 kernel_active;
  logic                 stall_cond;
  logic                 thresh_hit;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 block_d, block_q;

  // Saturating increment: the count parks at its maximum instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == CNT_MAX) sat_inc = v;
    else              sat_inc = v + 1'b1;
  endfunction

  always_comb begin
    proc0_stall   = ~inst_idle_sigs[0] &
                    (axis_block_sigs[0] | axis_block_sigs[1] | inst_block_sigs[0]);
    kernel_active = ~inst_idle_sigs[2] & ~inst_idle_sigs[1];
    stall_cond    = proc0_stall & kernel_active;
    // cnt >= THRESHOLD-1, written as cnt+1 >= THRESHOLD so THRESHOLD=1 stays a real compare
    thresh_hit    = ({1'b0, cnt_q} + (CNT_WIDTH+1)'(1)) >= THRESH_EX;
    cnt_d         = stall_cond ? sat_inc(cnt_q) : '0;
    block_d       = stall_cond & thresh_hit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      block_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  assign block = block_q;

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Directed bench for deadlock_idx0_monitor: default instance plus a THRESHOLD=1,
// CNT_WIDTH=2 instance, both driven identically and scored against a reference model.
module tb_deadlock_idx0_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [2:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;
  logic       block_a;
  logic       block_b;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_cnt_a, m_cnt_b;
  int q_blk_a[$];
  int q_blk_b[$];
  int q_cnt_b[$];

  always #5 clock = ~clock;

  deadlock_idx0_monitor #(.THRESHOLD(8), .CNT_WIDTH(8)) dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .block(block_a)
  );

  deadlock_idx0_monitor #(.THRESHOLD(1), .CNT_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .block(block_b)
  );

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, predict the outcome of the next rising
  // edge into the scoreboard, then compare once the DUT has registered it.
  task automatic step(input logic [1:0] ab, input logic [2:0] idl, input logic ib,
                      input string tag);
    bit stall;
    @(negedge clock);
    reset           = 1'b0;
    axis_block_sigs = ab;
    inst_idle_sigs  = idl;
    inst_block_sigs = ib;
    stall = (idl == 3'b000) && (ab != 2'b00 || ib);
    q_blk_a.push_back((stall && m_cnt_a >= 7) ? 1 : 0);
    q_blk_b.push_back((stall && m_cnt_b >= 0) ? 1 : 0);
    m_cnt_a = stall ? ((m_cnt_a < 255) ? m_cnt_a + 1 : 255) : 0;
    m_cnt_b = stall ? ((m_cnt_b < 3) ? m_cnt_b + 1 : 3) : 0;
    q_cnt_b.push_back(m_cnt_b);
    @(posedge clock);
    #1;
    chk({tag, "_blk_a"}, int'(block_a), q_blk_a.pop_front());
    chk({tag, "_blk_b"}, int'(block_b), q_blk_b.pop_front());
    chk({tag, "_cnt_b"}, int'(dut_b.cnt_q), q_cnt_b.pop_front());
  endtask

  initial begin
    reset           = 1'b1;
    axis_block_sigs = '0;
    inst_idle_sigs  = '0;
    inst_block_sigs = '0;
    m_cnt_a = 0;
    m_cnt_b = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_blk_a", int'(block_a), 0);
    chk("rst_cnt_a", int'(dut_a.cnt_q), 0);
    chk("rst_blk_b", int'(block_b), 0);

    // 1: quiet inputs after reset
    for (int i = 0; i < 20; i++) step(2'b00, 3'b000, 1'b0, "quiet");
    chk("quiet_cnt_a", int'(dut_a.cnt_q), 0);

    // 2: input-stream stall held, then dropped
    for (int i = 0; i < 10; i++) step(2'b10, 3'b000, 1'b0, "rd_stall");
    step(2'b00, 3'b000, 1'b0, "rd_drop");

    // 3: single-cycle gap restarts the count
    for (int i = 0; i < 5; i++) step(2'b01, 3'b000, 1'b0, "wr_burst1");
    step(2'b00, 3'b000, 1'b0, "wr_gap");
    for (int i = 0; i < 8; i++) step(2'b01, 3'b000, 1'b0, "wr_burst2");
    step(2'b00, 3'b000, 1'b0, "wr_drop");

    // 4: done-not-continued stall, then suppressed by idle bits
    for (int i = 0; i < 10; i++) step(2'b00, 3'b000, 1'b1, "done_stall");
    for (int i = 0; i < 10; i++) step(2'b00, 3'b101, 1'b1, "done_idle");
    for (int i = 0; i < 10; i++) step(2'b11, 3'b010, 1'b1, "chan_idle");
    for (int i = 0; i < 10; i++) step(2'b11, 3'b001, 1'b1, "proc_idle");
    // several sources at once count once
    for (int i = 0; i < 9; i++) step(2'b11, 3'b000, 1'b1, "multi_src");
    step(2'b00, 3'b000, 1'b0, "multi_drop");

    // 5: asynchronous reset while block is high
    for (int i = 0; i < 8; i++) step(2'b10, 3'b000, 1'b0, "pre_rst");
    chk("pre_rst_high", int'(block_a), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_blk_a", int'(block_a), 0);
    chk("async_rst_cnt_a", int'(dut_a.cnt_q), 0);
    chk("async_rst_blk_b", int'(block_b), 0);
    m_cnt_a = 0;
    m_cnt_b = 0;
    @(posedge clock);
    #1;
    chk("held_rst_blk_a", int'(block_a), 0);
    for (int i = 0; i < 9; i++) step(2'b10, 3'b000, 1'b0, "post_rst");

    // 6: long stall drives the small instance into saturation
    step(2'b00, 3'b000, 1'b0, "sat_clear");
    for (int i = 0; i < 10; i++) step(2'b10, 3'b000, 1'b0, "sat_hold");
    chk("sat_cnt_b", int'(dut_b.cnt_q), 3);
    step(2'b00, 3'b000, 1'b0, "sat_drop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
